// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-ported data RAM between the CPU
// load/store path and a debug/loader port, one access per cycle.
//
// Ports:
//   clk, reset           system clock, async active-high reset
//   cpu_* / dbg_*        requester side: req/we/addr/wdata in,
//                        gnt/rvalid/rdata out
//   ram_address/ram_data registered RAM address and write data
//   ram_rden/ram_wren    registered RAM read/write enables
//   ram_q                RAM read data, valid the cycle after a read
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    owner_e            last_owner_q, last_owner_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              rd_valid_q, rd_valid_d;
    owner_e            rd_owner_q, rd_owner_d;

    logic cpu_elig;
    logic dbg_elig;
    logic cpu_win;
    logic dbg_win;

    // A port that holds the RAM this cycle sits out the next decision,
    // so a lone requester gets at most every other cycle.
    always_comb begin
        cpu_elig = cpu_req & ~cpu_gnt_q;
        dbg_elig = dbg_req & ~dbg_gnt_q;
        cpu_win  = cpu_elig & (~dbg_elig | (last_owner_q == OWN_DBG));
        dbg_win  = dbg_elig & (~cpu_elig | (last_owner_q == OWN_CPU));
    end

    always_comb begin
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cpu_gnt_d    = cpu_win;
        dbg_gnt_d    = dbg_win;
        rden_d       = 1'b0;
        wren_d       = 1'b0;
        // The read on the pins now returns ram_q next cycle; tag it
        // with whichever port holds the pins now.
        rd_valid_d   = rden_q;
        rd_owner_d   = dbg_gnt_q ? OWN_DBG : OWN_CPU;

        if (cpu_win) begin
            last_owner_d = OWN_CPU;
            addr_d       = cpu_addr;
            data_d       = cpu_wdata;
            wren_d       = cpu_we;
            rden_d       = ~cpu_we;
        end else if (dbg_win) begin
            last_owner_d = OWN_DBG;
            addr_d       = dbg_addr;
            data_d       = dbg_wdata;
            wren_d       = dbg_we;
            rden_d       = ~dbg_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_DBG;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= OWN_CPU;
        end else begin
            last_owner_q <= last_owner_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rden_q       <= rden_d;
            wren_q       <= wren_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign cpu_gnt     = cpu_gnt_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_rden    = rden_q;
    assign ram_wren    = wren_q;

    assign cpu_rvalid  = rd_valid_q & (rd_owner_q == OWN_CPU);
    assign dbg_rvalid  = rd_valid_q & (rd_owner_q == OWN_DBG);
    assign cpu_rdata   = cpu_rvalid ? ram_q : '0;
    assign dbg_rdata   = dbg_rvalid ? ram_q : '0;

endmodule
